regfile_seq_ctrl: RTL
=====================

Name: regfile_seq_ctrl

Overview:
Multi-cycle sequencer and arbiter in front of the 8x16 register file with its accumulator (res).
- Accepts register-file commands from the core decode stage over a valid/ready handshake, and optionally from a debug read port.
- Arbitrates between the two requesters and drives the register file's reg_sel, cpyin, cpyout and accumulator write-enable with guaranteed settle time.
- Reports completion with a one-cycle done pulse; sits between decode and register_file.

Parameters:
DATA_W, 16, datapath width of reg_val/res_val
SEL_W, 3, register select width (2**SEL_W registers)
SETTLE_CYCLES, 1, cycles reg_sel is held stable before a strobe (1..7)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
core_valid  in  1  core command valid
core_ready  out  1  controller can accept core command this cycle
core_cmd  in  2  00 NOP, 01 CPYIN (reg->acc), 10 CPYOUT (acc->reg), 11 ALUWR (alu->acc)
core_sel  in  SEL_W  target register
core_done  out  1  one-cycle pulse: core command completed
dbg_valid  in  1  debug read request
dbg_ready  out  1  debug request accepted this cycle
dbg_sel  in  SEL_W  register to read
dbg_data  out  DATA_W  captured register value
dbg_done  out  1  one-cycle pulse: dbg_data valid
rf_reg_val  in  DATA_W  reg_val from register file
rf_reg_sel  out  SEL_W  to register file reg_sel
rf_cpyin  out  1  one-cycle strobe, reg->acc
rf_cpyout  out  1  one-cycle strobe, acc->reg
rf_acc_we  out  1  one-cycle strobe, latch ALU result into acc
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE, settle counter 0, prio flag 0 (debug-first), rf_reg_sel 0, all strobes 0, core_done/dbg_done 0, dbg_data 0, busy 0.
- core_ready and dbg_ready are high only in IDLE, and only for the requester that wins arbitration. A transfer occurs when valid && ready. The accepted command and sel are latched on that edge.
- Arbitration in IDLE:
  - Only one requester valid: that requester wins.
  - Both valid: prio=0 grants debug, prio=1 grants core.
  - prio updates only on a contested grant; it then points to the loser (round-robin, starvation-free).
- FSM: IDLE -> SETTLE -> STROBE -> DONE -> IDLE.
  - SETTLE: rf_reg_sel = latched sel. Counter counts SETTLE_CYCLES cycles, then moves to STROBE.
  - STROBE (exactly 1 cycle):
    - CPYIN: rf_cpyin=1.
    - CPYOUT: rf_cpyout=1.
    - ALUWR: rf_acc_we=1.
    - NOP: no strobe.
    - Debug: no strobe; dbg_data <= rf_reg_val at end of this cycle.
  - DONE: rf_reg_sel held; core_done or dbg_done pulses 1 cycle; next state IDLE.
- Latency, with SETTLE_CYCLES=1: accept at edge N; strobe during cycle N+2; done during cycle N+3; next accept at the earliest edge N+4.
- Strobes are mutually exclusive and never asserted outside STROBE.
- rf_reg_sel changes only on acceptance and is held through DONE. It keeps its last value in IDLE.
- Reset asserted mid-operation:
  - Abandons the command; no done pulse.
  - Strobes are deasserted on the same edge.
  - An in-flight dbg_data update is lost; dbg_data clears to 0.
- core_valid deasserted while not ready: no effect; the requester is not required to hold valid.
- NOP follows the full FSM path, so done timing is uniform.

Optional Feature:
REGCTRL_DBG_EN
- Defined: debug port and arbiter present as above.
- Undefined:
  - dbg_ready, dbg_done and dbg_data are tied to 0 and dbg_valid is ignored.
  - Arbiter and prio flag are removed; core_ready = (state==IDLE).
  - Core timing is identical.

Decomposition:
- Shared package regfile_pkg:
  - command encodings CMD_NOP/CMD_CPYIN/CMD_CPYOUT/CMD_ALUWR;
  - FSM state typedef (IDLE, SETTLE, STROBE, DONE);
  - DATA_W/SEL_W defaults.
- One natural sub-module: rr_arb2, a 2-requester round-robin arbiter with the prio flag. It is instantiated only under REGCTRL_DBG_EN.

Test Plan:
- Reset then idle: all outputs 0; core_ready=1 after reset deasserts.
- Core CPYIN sel=5 accepted at edge 0 -> rf_reg_sel=5 from cycle 1; rf_cpyin=1 only in cycle 2; core_done in cycle 3; core_ready=1 in cycle 4.
- Debug read sel=3 with rf_reg_val=16'hBEEF -> dbg_data=16'hBEEF and dbg_done=1 in cycle 3; no rf_* strobe is ever asserted.
- core_valid and dbg_valid held high continuously:
  - grants alternate debug, core, debug, core;
  - each done pulse is 4 cycles apart.
- SETTLE_CYCLES=3, core CPYOUT sel=7 -> rf_cpyout is asserted in cycle 4 only; core_done in cycle 5.
- Reset asserted during STROBE of ALUWR -> rf_acc_we=0 the next cycle, no core_done, state IDLE, prio=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared encodings and defaults for the register-file sequencer slice.
package regfile_pkg;

  localparam int REGFILE_DATA_W = 16;
  localparam int REGFILE_SEL_W  = 3;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_CPYIN  = 2'b01,
    CMD_CPYOUT = 2'b10,
    CMD_ALUWR  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    STROBE,
    DONE
  } state_e;

endpackage

// File: rtl/regfile_seq_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; requester a is the debug port, b the core.
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic prio;

  // prio=0 favours a; b is granted whenever a is not, so an idle core sees ready
  assign gnt_a = req_a && (!req_b || !prio);
  assign gnt_b = !gnt_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (en && req_a && req_b) begin
      prio <= ~prio;
    end
  end

endmodule

// File: rtl/regfile_seq_ctrl.sv
// Sequencer/arbiter in front of the register file. Debug read port is built
// only when REGCTRL_DBG_EN is defined.
module regfile_seq_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_W        = REGFILE_DATA_W,
  parameter int SEL_W         = REGFILE_SEL_W,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_valid,
  output logic              core_ready,
  input  logic [1:0]        core_cmd,
  input  logic [SEL_W-1:0]  core_sel,
  output logic              core_done,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic [SEL_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_done,
  input  logic [DATA_W-1:0] rf_reg_val,
  output logic [SEL_W-1:0]  rf_reg_sel,
  output logic              rf_cpyin,
  output logic              rf_cpyout,
  output logic              rf_acc_we,
  output logic              busy
);

  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYCLES - 1);

  state_e           state, state_nxt;
  logic [2:0]       cnt;
  cmd_e             cmd_q;
  logic             dbg_q;
  logic [SEL_W-1:0] sel_q;
  logic             accept_en;
  logic             gnt_core, gnt_dbg;
  logic             core_take, dbg_take;

  // No transfer is accepted while reset is being applied
  assign accept_en = (state == IDLE) && !reset;

`ifdef REGCTRL_DBG_EN
  logic [DATA_W-1:0] dbg_data_q;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (accept_en),
    .req_a (dbg_valid),
    .req_b (core_valid),
    .gnt_a (gnt_dbg),
    .gnt_b (gnt_core)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_data_q <= '0;
    end else if (state == STROBE && dbg_q) begin
      dbg_data_q <= rf_reg_val;
    end
  end

  assign dbg_ready = accept_en && gnt_dbg;
  assign dbg_done  = (state == DONE) && dbg_q;
  assign dbg_data  = dbg_data_q;
`else
  logic unused_dbg;
  assign unused_dbg = ^{dbg_valid, dbg_sel, rf_reg_val};
  assign gnt_dbg    = 1'b0;
  assign gnt_core   = 1'b1;
  assign dbg_ready  = 1'b0;
  assign dbg_done   = 1'b0;
  assign dbg_data   = '0;
`endif

  assign core_ready = accept_en && gnt_core;
  assign core_take  = core_valid && core_ready;
  assign dbg_take   = dbg_valid && dbg_ready;
  assign rf_reg_sel = sel_q;
  assign busy       = (state != IDLE);

  // Command capture on acceptance; sel then stays put through DONE and IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= '0;
      cmd_q <= CMD_NOP;
      dbg_q <= 1'b0;
    end else if (dbg_take) begin
      sel_q <= dbg_sel;
      cmd_q <= CMD_NOP;
      dbg_q <= 1'b1;
    end else if (core_take) begin
      sel_q <= core_sel;
      cmd_q <= cmd_e'(core_cmd);
      dbg_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == SETTLE && cnt != SETTLE_LAST) begin
        cnt <= cnt + 3'd1;
      end else begin
        cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rf_cpyin  = 1'b0;
    rf_cpyout = 1'b0;
    rf_acc_we = 1'b0;
    core_done = 1'b0;
    case (state)
      IDLE:   if (core_take || dbg_take) state_nxt = SETTLE;
      SETTLE: if (cnt == SETTLE_LAST) state_nxt = STROBE;
      STROBE: begin
        state_nxt = DONE;
        if (!dbg_q) begin
          rf_cpyin  = (cmd_q == CMD_CPYIN);
          rf_cpyout = (cmd_q == CMD_CPYOUT);
          rf_acc_we = (cmd_q == CMD_ALUWR);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        core_done = !dbg_q;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
